lsu_mem_sched: RTL and testbench

- Sequences the single data-memory port shared by two requesters.
- Requester 1 is the LSQ load-issue path; requester 2 is the store-commit path, which carries ROB-retired stores.
- Handles byte-lane generation for LB/SB, fixed-latency memory timing, load response return to the CDB side, and flush of speculative loads.
- Sits between the LSQ/LSU and the data memory.

---
 rtl/lsu_mem_sched_pkg.sv | 26 ++
 rtl/lsu_mem_sched_byte_lane.sv | 42 ++++
 rtl/lsu_mem_sched.sv | 205 ++++++++++++++++++++
 tb/tb_lsu_mem_sched.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_sched_pkg.sv
// Shared opcodes, widths and FSM encoding for the LSU data-memory scheduler.
package lsu_mem_sched_pkg;

    localparam int LS_OP_W = 4;

    localparam logic [LS_OP_W-1:0] OP_LB = 4'd7;
    localparam logic [LS_OP_W-1:0] OP_LW = 4'd8;
    localparam logic [LS_OP_W-1:0] OP_SB = 4'd9;
    localparam logic [LS_OP_W-1:0] OP_SW = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic is_load_op(input logic [LS_OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LW);
    endfunction

    function automatic logic is_store_op(input logic [LS_OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_mem_sched_byte_lane.sv
// Store strobe/data lane generation and load byte extraction with sign extension.
module lsu_byte_lane
    import lsu_mem_sched_pkg::*;
(
    input  logic [LS_OP_W-1:0] op,
    input  logic [1:0]         byte_off,
    input  logic [31:0]        st_data,
    input  logic [31:0]        rdata,
    output logic [3:0]         wstrb,
    output logic [31:0]        wdata,
    output logic [31:0]        ld_data
);

    logic [7:0] ld_byte;

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        case (op)
            OP_SB: begin
                wstrb = 4'b0001 << byte_off;
                wdata = {4{st_data[7:0]}};
            end
            OP_SW: begin
                wstrb = 4'b1111;
                wdata = st_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (byte_off)
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_data = (op == OP_LB) ? {{24{ld_byte[7]}}, ld_byte} : rdata;
    end

endmodule

// File: rtl/lsu_mem_sched.sv
// Single data-memory port scheduler: load-issue vs store-commit arbitration,
// fixed-latency access timing, load response return and load flush.
module lsu_mem_sched
    import lsu_mem_sched_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_op,
    input  logic [5:0]  ld_rd,
    input  logic [31:0] ld_pc,
    input  logic        st_req_valid,
    output logic        st_req_ready,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_op,
    input  logic [31:0] st_data,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [31:0] mem_rdata,
    output logic        ld_resp_valid,
    output logic [5:0]  ld_resp_rd,
    output logic [31:0] ld_resp_pc,
    output logic [31:0] ld_resp_data,
    output logic        op_err,
    output logic        busy
);

    localparam logic [3:0] LAT_LOAD     = 4'(MEM_LAT - 1);
    localparam logic [7:0] STARVE_LIM   = 8'(STARVE_MAX);
    localparam bit         ST_SKIP_WAIT = (MEM_LAT == 1);

    state_t state;
    state_t state_nx;

    logic        is_ld_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] pc_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic [5:0]  rd_q;
    logic        drop_q;
    logic        op_err_q;
    logic [3:0]  lat_q;
    logic [7:0]  starve_q;

    logic        idle_ok;
    logic        starve_hit;
    logic        ld_go;
    logic        st_go;
    logic        op_legal;
    logic        lat_done;

    logic [3:0]  bl_wstrb;
    logic [31:0] bl_wdata;
    logic [31:0] bl_ld_data;

    lsu_byte_lane u_lane (
        .op       (op_q),
        .byte_off (addr_q[1:0]),
        .st_data  (data_q),
        .rdata    (rdata_q),
        .wstrb    (bl_wstrb),
        .wdata    (bl_wdata),
        .ld_data  (bl_ld_data)
    );

    // Readiness already encodes the arbitration result, so valid&ready is a grant.
    always_comb begin
        idle_ok      = (state == S_IDLE) && !rst;
        starve_hit   = (starve_q == STARVE_LIM);
        ld_req_ready = idle_ok && !flush && !(st_req_valid && starve_hit);
        st_req_ready = idle_ok && !(ld_req_valid && !flush && !starve_hit);
        ld_go        = ld_req_valid && ld_req_ready;
        st_go        = st_req_valid && st_req_ready;
        op_legal     = ld_go ? is_load_op(ld_op) : is_store_op(st_op);
        lat_done     = (lat_q == 4'd0);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if ((ld_go || st_go) && op_legal) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                state_nx = (!is_ld_q && ST_SKIP_WAIT) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (is_ld_q) begin
                    if (lat_done) state_nx = S_RESP;
                end else if (lat_q <= 4'd1) begin
                    state_nx = S_IDLE;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            is_ld_q  <= 1'b0;
            op_q     <= 4'h0;
            addr_q   <= 32'h0;
            pc_q     <= 32'h0;
            data_q   <= 32'h0;
            rdata_q  <= 32'h0;
            rd_q     <= 6'h0;
            drop_q   <= 1'b0;
            op_err_q <= 1'b0;
            lat_q    <= 4'h0;
            starve_q <= 8'h0;
        end else begin
            state    <= state_nx;
            op_err_q <= (ld_go || st_go) && !op_legal;

            if (ld_go) begin
                is_ld_q <= 1'b1;
                op_q    <= ld_op;
                addr_q  <= ld_addr;
                rd_q    <= ld_rd;
                pc_q    <= ld_pc;
                data_q  <= 32'h0;
            end else if (st_go) begin
                is_ld_q <= 1'b0;
                op_q    <= st_op;
                addr_q  <= st_addr;
                rd_q    <= 6'h0;
                pc_q    <= 32'h0;
                data_q  <= st_data;
            end

            if (!st_req_valid || st_go) begin
                starve_q <= 8'h0;
            end else if (ld_go && !starve_hit) begin
                starve_q <= starve_q + 8'd1;
            end

            if (state == S_ISSUE) begin
                lat_q <= LAT_LOAD;
            end else if (state == S_WAIT && !lat_done) begin
                lat_q <= lat_q - 4'd1;
            end

            if (state == S_WAIT && lat_done && is_ld_q) begin
                rdata_q <= mem_rdata;
            end

            // Once squashed, the load keeps its timing but never responds.
            if (state_nx == S_IDLE) begin
                drop_q <= 1'b0;
            end else if (flush && is_ld_q && state != S_IDLE) begin
                drop_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        mem_wstrb     = 4'h0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        ld_resp_valid = 1'b0;
        ld_resp_rd    = 6'h0;
        ld_resp_pc    = 32'h0;
        ld_resp_data  = 32'h0;
        case (state)
            S_ISSUE: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (is_ld_q) begin
                    mem_read_en = 1'b1;
                end else begin
                    mem_write_en = 1'b1;
                    mem_wstrb    = bl_wstrb;
                    mem_wdata    = bl_wdata;
                end
            end
            S_RESP: begin
                if (!drop_q && !flush) begin
                    ld_resp_valid = 1'b1;
                    ld_resp_rd    = rd_q;
                    ld_resp_pc    = pc_q;
                    ld_resp_data  = bl_ld_data;
                end
            end
            default: ;
        endcase
    end

    assign op_err = op_err_q;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_lsu_mem_sched.sv
// Self-checking bench for lsu_mem_sched: directed scenarios plus a randomized
// run against a cycle-timeline reference model with its own memory image.
module tb_lsu_mem_sched;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_req_valid = 1'b0;
    logic        ld_req_ready;
    logic [31:0] ld_addr = 32'h0;
    logic [3:0]  ld_op = 4'h0;
    logic [5:0]  ld_rd = 6'h0;
    logic [31:0] ld_pc = 32'h0;
    logic        st_req_valid = 1'b0;
    logic        st_req_ready;
    logic [31:0] st_addr = 32'h0;
    logic [3:0]  st_op = 4'h0;
    logic [31:0] st_data = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_rdata = 32'h0;
    logic        ld_resp_valid;
    logic [5:0]  ld_resp_rd;
    logic [31:0] ld_resp_pc;
    logic [31:0] ld_resp_data;
    logic        op_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] phys    [16];
    logic [31:0] ref_mem [16];
    int          rd_due = -1;
    logic [31:0] rd_val = 32'h0;

    lsu_mem_sched #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_addr(ld_addr), .ld_op(ld_op), .ld_rd(ld_rd), .ld_pc(ld_pc),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_addr(st_addr), .st_op(st_op), .st_data(st_data),
        .flush(flush),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_rdata(mem_rdata),
        .ld_resp_valid(ld_resp_valid), .ld_resp_rd(ld_resp_rd),
        .ld_resp_pc(ld_resp_pc), .ld_resp_data(ld_resp_data),
        .op_err(op_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory: read data is only valid in the due cycle, noise otherwise.
    always @(negedge clk) begin
        if (mem_write_en)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) phys[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        if (mem_read_en) begin
            rd_due = cyc + LAT;
            rd_val = phys[mem_addr[5:2]];
        end
        mem_rdata = (cyc == rd_due) ? rd_val : $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        logic [110:0] outs;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {ld_req_ready, st_req_ready, busy, mem_read_en, mem_write_en,
                mem_wstrb, ld_resp_valid, op_err, mem_addr, mem_wdata, ld_resp_data};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got %h want 0", outs);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ld_req_ready, st_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 11", {ld_req_ready, st_req_ready});
        end
    endtask

    task automatic test_lb_sign();
        phys[0]    = 32'h80FF1234;
        ref_mem[0] = 32'h80FF1234;
        tick();
        ld_req_valid = 1'b1;
        ld_op        = 4'd7;
        ld_addr      = 32'h1003;
        ld_rd        = 6'd5;
        ld_pc        = 32'h400;
        @(negedge clk);
        n_checks++;
        if (ld_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_ready got %b want 1", ld_req_ready);
        end
        tick();
        ld_req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (mem_read_en !== 1'b1 || mem_addr !== 32'h1000) begin
                    n_fail++;
                    $display("FAIL lb_issue got en=%b addr=%h want en=1 addr=00001000", mem_read_en, mem_addr);
                end
            end
            n_checks++;
            if (ld_resp_valid !== (c == 4)) begin
                n_fail++;
                $display("FAIL lb_resp_valid c%0d got %b want %b", c, ld_resp_valid, c == 4);
            end
            if (c == 4) begin
                n_checks++;
                if (ld_resp_data !== 32'hFFFFFF80 || ld_resp_rd !== 6'd5 || ld_resp_pc !== 32'h400) begin
                    n_fail++;
                    $display("FAIL lb_resp got data=%h rd=%0d pc=%h want ffffff80 5 00000400",
                             ld_resp_data, ld_resp_rd, ld_resp_pc);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (ld_req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lb_next_ready got %b want 1", ld_req_ready);
                end
            end
        end
    endtask

    task automatic test_sb_lanes();
        int resps = 0;
        ref_mem[0][23:16] = 8'hE5;
        tick();
        st_req_valid = 1'b1;
        st_op        = 4'd9;
        st_addr      = 32'h2002;
        st_data      = 32'hABCD00E5;
        tick();
        st_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            resps += int'(ld_resp_valid);
            if (c == 1) begin
                n_checks++;
                if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_wstrb !== 4'b0100 ||
                    mem_wdata !== 32'hE5E5E5E5 || mem_addr !== 32'h2000) begin
                    n_fail++;
                    $display("FAIL sb_issue got we=%b re=%b strb=%b wd=%h addr=%h want 1 0 0100 e5e5e5e5 00002000",
                             mem_write_en, mem_read_en, mem_wstrb, mem_wdata, mem_addr);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (mem_write_en !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sb_wait got we=%b busy=%b want 0 1", mem_write_en, busy);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (st_req_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_next_ready got rdy=%b busy=%b want 1 0", st_req_ready, busy);
                end
            end
        end
        n_checks++;
        if (resps != 0) begin
            n_fail++;
            $display("FAIL sb_no_resp got %0d want 0", resps);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [110:0] outs;
        int resps = 0;
        tick();
        ld_req_valid = 1'b1;
        ld_op        = 4'd8;
        ld_addr      = 32'h1010;
        tick();
        ld_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        outs = {ld_req_ready, st_req_ready, busy, mem_read_en, mem_write_en,
                mem_wstrb, ld_resp_valid, op_err, mem_addr, mem_wdata, ld_resp_data};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outs got %h want 0", outs);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ld_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready got %b want 1", ld_req_ready);
        end
        repeat (6) begin
            @(negedge clk);
            resps += int'(ld_resp_valid);
        end
        n_checks++;
        if (resps != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_resp got %0d want 0", resps);
        end
    endtask

    task automatic test_starvation();
        string got = "";
        string want = "LLLLSL";
        int    budget = 100;
        tick();
        ld_req_valid = 1'b1;
        ld_op        = 4'd8;
        ld_addr      = 32'h1004;
        st_req_valid = 1'b1;
        st_op        = 4'd10;
        st_addr      = 32'h1008;
        st_data      = 32'h12345678;
        ref_mem[2]   = 32'h12345678;
        while (got.len() < 6 && budget > 0) begin
            @(negedge clk);
            if (ld_req_valid && ld_req_ready) got = {got, "L"};
            else if (st_req_valid && st_req_ready) got = {got, "S"};
            budget--;
        end
        tick();
        idle_inputs();
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL starvation_order got %s want %s", got, want);
        end
        repeat (8) tick();
    endtask

    task automatic test_flush_wait();
        int reads = 0;
        int resps = 0;
        tick();
        ld_req_valid = 1'b1;
        ld_op        = 4'd8;
        ld_addr      = 32'h1008;
        tick();
        ld_req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                tick();
                flush = (c == 2);
            end
            @(negedge clk);
            reads += int'(mem_read_en);
            resps += int'(ld_resp_valid);
            if (c == 4) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flush_resp_busy got %b want 1", busy);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (ld_req_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_idle got rdy=%b busy=%b want 1 0", ld_req_ready, busy);
                end
            end
        end
        n_checks++;
        if (reads != 1 || resps != 0) begin
            n_fail++;
            $display("FAIL flush_counts got reads=%0d resps=%0d want 1 0", reads, resps);
        end
    endtask

    task automatic test_illegal_op();
        tick();
        ld_req_valid = 1'b1;
        ld_op        = 4'd3;
        ld_addr      = 32'h1000;
        @(negedge clk);
        n_checks++;
        if (ld_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_ready got %b want 1", ld_req_ready);
        end
        tick();
        ld_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (op_err !== 1'b1 || mem_read_en !== 1'b0 || busy !== 1'b0 || ld_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_c1 got err=%b re=%b busy=%b rdy=%b want 1 0 0 1",
                     op_err, mem_read_en, busy, ld_req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (op_err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_c2 got err=%b want 0", op_err);
        end
    endtask

    task automatic test_random(input int n);
        int          free_c = 0;
        int          issue_c = -1;
        int          resp_c = -1;
        int          err_c = -1;
        int          acc_c = -1;
        int          starve = 0;
        bit          pend = 0;
        bit          drop = 0;
        bit          iss_ld = 0;
        bit          free, e_ldr, e_str, e_resp, lg, sg;
        logic [31:0] e_addr = 0;
        logic [31:0] e_wdata = 0;
        logic [3:0]  e_wstrb = 0;
        logic [31:0] e_data = 0;
        logic [5:0]  e_rd = 0;
        logic [31:0] e_pc = 0;
        logic [31:0] w;
        logic [7:0]  b8;
        int          off;
        for (int i = 0; i < n; i++) begin
            tick();
            ld_req_valid = ($urandom_range(2) != 0);
            st_req_valid = ($urandom_range(2) == 0);
            flush        = ($urandom_range(9) == 0);
            ld_op        = ($urandom_range(7) == 0) ? 4'd3 : ($urandom_range(1) ? 4'd7 : 4'd8);
            st_op        = ($urandom_range(7) == 0) ? 4'd12 : ($urandom_range(1) ? 4'd9 : 4'd10);
            ld_addr      = 32'h1000 + 32'($urandom_range(63));
            st_addr      = 32'h1000 + 32'($urandom_range(63));
            st_data      = $urandom;
            ld_rd        = 6'($urandom);
            ld_pc        = $urandom;
            @(negedge clk);

            free  = (cyc >= free_c);
            e_ldr = free && !flush && !(st_req_valid && starve == SMAX);
            e_str = free && !(ld_req_valid && !flush && starve != SMAX);
            n_checks++;
            if (ld_req_ready !== e_ldr || st_req_ready !== e_str) begin
                n_fail++;
                $display("FAIL rnd_ready cyc%0d got %b%b want %b%b", cyc, ld_req_ready, st_req_ready, e_ldr, e_str);
            end

            if (pend && flush && cyc > acc_c && cyc <= resp_c) drop = 1;
            e_resp = pend && (cyc == resp_c) && !drop;
            n_checks++;
            if (ld_resp_valid !== e_resp) begin
                n_fail++;
                $display("FAIL rnd_resp_valid cyc%0d got %b want %b", cyc, ld_resp_valid, e_resp);
            end
            if (e_resp) begin
                n_checks++;
                if (ld_resp_data !== e_data || ld_resp_rd !== e_rd || ld_resp_pc !== e_pc) begin
                    n_fail++;
                    $display("FAIL rnd_resp cyc%0d got %h/%0d/%h want %h/%0d/%h", cyc,
                             ld_resp_data, ld_resp_rd, ld_resp_pc, e_data, e_rd, e_pc);
                end
            end

            n_checks++;
            if (mem_read_en !== (cyc == issue_c && iss_ld) || mem_write_en !== (cyc == issue_c && !iss_ld)) begin
                n_fail++;
                $display("FAIL rnd_mem_en cyc%0d got re=%b we=%b want re=%b we=%b", cyc,
                         mem_read_en, mem_write_en, cyc == issue_c && iss_ld, cyc == issue_c && !iss_ld);
            end
            if (cyc == issue_c) begin
                n_checks++;
                if (mem_addr !== e_addr || (!iss_ld && (mem_wstrb !== e_wstrb || mem_wdata !== e_wdata)) ||
                    (iss_ld && mem_wstrb !== 4'h0)) begin
                    n_fail++;
                    $display("FAIL rnd_issue cyc%0d got %h/%b/%h want %h/%b/%h", cyc,
                             mem_addr, mem_wstrb, mem_wdata, e_addr, iss_ld ? 4'h0 : e_wstrb, e_wdata);
                end
            end

            n_checks++;
            if (op_err !== (cyc == err_c) || busy !== (cyc < free_c)) begin
                n_fail++;
                $display("FAIL rnd_err_busy cyc%0d got err=%b busy=%b want %b %b", cyc,
                         op_err, busy, cyc == err_c, cyc < free_c);
            end

            if (cyc >= resp_c) pend = 0;
            lg = ld_req_valid && e_ldr;
            sg = st_req_valid && e_str;
            if (lg) begin
                if (ld_op == 4'd7 || ld_op == 4'd8) begin
                    acc_c   = cyc;
                    issue_c = cyc + 1;
                    resp_c  = cyc + 2 + LAT;
                    free_c  = cyc + 3 + LAT;
                    iss_ld  = 1;
                    pend    = 1;
                    drop    = 0;
                    e_addr  = {ld_addr[31:2], 2'b00};
                    w       = ref_mem[ld_addr[5:2]];
                    off     = int'(ld_addr[1:0]);
                    b8      = 8'(w >> (8 * off));
                    e_data  = (ld_op == 4'd8) ? w : {{24{b8[7]}}, b8};
                    e_rd    = ld_rd;
                    e_pc    = ld_pc;
                end else begin
                    err_c = cyc + 1;
                end
            end
            if (sg) begin
                if (st_op == 4'd9 || st_op == 4'd10) begin
                    issue_c = cyc + 1;
                    free_c  = cyc + 1 + LAT;
                    iss_ld  = 0;
                    e_addr  = {st_addr[31:2], 2'b00};
                    off     = int'(st_addr[1:0]);
                    if (st_op == 4'd9) begin
                        e_wstrb = 4'(1 << off);
                        e_wdata = {4{st_data[7:0]}};
                        ref_mem[st_addr[5:2]][8*off +: 8] = st_data[7:0];
                    end else begin
                        e_wstrb = 4'hF;
                        e_wdata = st_data;
                        ref_mem[st_addr[5:2]] = st_data;
                    end
                end else begin
                    err_c = cyc + 1;
                end
            end
            if (!st_req_valid || sg) starve = 0;
            else if (lg && starve < SMAX) starve++;
        end
        tick();
        idle_inputs();
        repeat (8) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            phys[i]    = $urandom;
            ref_mem[i] = phys[i];
        end
        test_reset();
        test_lb_sign();
        test_sb_lanes();
        test_reset_mid_load();
        test_starvation();
        test_flush_wait();
        test_illegal_op();
        test_random(800);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
